mem_wb: RTL and testbench

- MEM/WB pipeline register of the five-stage core.
- Captures the MEM-stage result each cycle and drives the register file write port (we/waddr/wdata) and the HI/LO write port one cycle later.
- Implements the pipeline stall, bubble-insertion and flush rules for the write-back boundary.
- Keeps a retired-instruction counter for bring-up and CPI measurement.

---
 rtl/mem_wb.sv | 90 +++++++++
 tb/tb_mem_wb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb.sv
// MEM/WB pipeline register: drives the regfile and HI/LO write ports one cycle after MEM
// and counts retired instructions. Define LLBIT_EN to add the LL/SC llbit write fields.
module mem_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_whilo,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
  output logic              wb_valid,
`ifdef LLBIT_EN
  input  logic              mem_llbit_we,
  input  logic              mem_llbit_value,
  output logic              wb_llbit_we,
  output logic              wb_llbit_value,
`endif
  output logic [CNT_W-1:0]  retired_cnt
);

  // Only the MEM and WB hold bits matter at this boundary.
  logic unused_stall;
  assign unused_stall = &{1'b0, stall[3:0]};

  logic load_bubble;
  logic capture;
  assign load_bubble = flush || (stall[4] && !stall[5]);
  assign capture     = !stall[4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_wd       <= '0;
      wb_wreg     <= 1'b0;
      wb_wdata    <= '0;
      wb_whilo    <= 1'b0;
      wb_hi       <= '0;
      wb_lo       <= '0;
      wb_valid    <= 1'b0;
      retired_cnt <= '0;
    end else if (load_bubble) begin
      // A held MEM with a moving WB must not write the same instruction twice.
      wb_wd    <= '0;
      wb_wreg  <= 1'b0;
      wb_wdata <= '0;
      wb_whilo <= 1'b0;
      wb_hi    <= '0;
      wb_lo    <= '0;
      wb_valid <= 1'b0;
    end else if (capture) begin
      wb_wd    <= mem_wd;
      wb_wreg  <= mem_wreg && mem_valid;
      wb_wdata <= mem_wdata;
      wb_whilo <= mem_whilo && mem_valid;
      wb_hi    <= mem_hi;
      wb_lo    <= mem_lo;
      wb_valid <= mem_valid;
      if (mem_valid) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

`ifdef LLBIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_llbit_we    <= 1'b0;
      wb_llbit_value <= 1'b0;
    end else if (load_bubble) begin
      wb_llbit_we    <= 1'b0;
      wb_llbit_value <= 1'b0;
    end else if (capture) begin
      wb_llbit_we    <= mem_llbit_we && mem_valid;
      wb_llbit_value <= mem_llbit_value;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for mem_wb; the counter is built 4 bits wide so its wrap is reachable.
module tb_mem_wb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [5:0]        stall;
  logic              flush;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_wd;
  logic              mem_wreg;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_whilo;
  logic [DATA_W-1:0] mem_hi;
  logic [DATA_W-1:0] mem_lo;
  logic [ADDR_W-1:0] wb_wd;
  logic              wb_wreg;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_whilo;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;
  logic              wb_valid;
  logic [CNT_W-1:0]  retired_cnt;
`ifdef LLBIT_EN
  logic mem_llbit_we, mem_llbit_value, wb_llbit_we, wb_llbit_value;
`endif

  int total = 0;
  int bad   = 0;
  logic [CNT_W-1:0]  exp_cnt = '0;
  logic [DATA_W-1:0] exp_q[$];

  mem_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .wb_whilo(wb_whilo),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_valid(wb_valid),
`ifdef LLBIT_EN
    .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
    .wb_llbit_we(wb_llbit_we), .wb_llbit_value(wb_llbit_value),
`endif
    .retired_cnt(retired_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic v, input logic [ADDR_W-1:0] wd, input logic wr,
                         input logic [DATA_W-1:0] wdata, input logic whl,
                         input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo);
    mem_valid = v; mem_wd = wd; mem_wreg = wr; mem_wdata = wdata;
    mem_whilo = whl; mem_hi = hi; mem_lo = lo;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = '0; flush = 1'b0;
`ifdef LLBIT_EN
    mem_llbit_we = 1'b0; mem_llbit_value = 1'b0;
`endif
    set_mem(1'b1, 5'd3, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h1, 32'h2);
    #12;
    total++; if (wb_wreg !== 1'b0) begin bad++; $display("FAIL reset_wreg got=%0h want=0", wb_wreg); end
    total++; if (wb_wdata !== '0) begin bad++; $display("FAIL reset_wdata got=%0h want=0", wb_wdata); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", wb_valid); end
    total++; if (retired_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", retired_cnt); end
    set_mem(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    rst = 1'b0;
    step();
  endtask

  task automatic test_capture();
    set_mem(1'b1, 5'd5, 1'b1, 32'h0000_000A, 1'b0, '0, '0);
    step(); exp_cnt++;
    total++; if (wb_wd !== 5'd5) begin bad++; $display("FAIL cap_wd got=%0d want=5", wb_wd); end
    total++; if (wb_wreg !== 1'b1) begin bad++; $display("FAIL cap_wreg got=%0h want=1", wb_wreg); end
    total++; if (wb_wdata !== 32'h0000_000A) begin bad++; $display("FAIL cap_wdata got=%0h want=a", wb_wdata); end
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL cap_valid got=%0h want=1", wb_valid); end
    total++; if (retired_cnt !== 4'd1) begin bad++; $display("FAIL cap_cnt got=%0d want=1", retired_cnt); end
  endtask

  task automatic test_invalid_capture();
    set_mem(1'b0, 5'd9, 1'b1, 32'h0000_0055, 1'b1, 32'h0000_0066, 32'h0000_0077);
    step();
    total++; if (wb_wreg !== 1'b0) begin bad++; $display("FAIL inv_wreg got=%0h want=0", wb_wreg); end
    total++; if (wb_whilo !== 1'b0) begin bad++; $display("FAIL inv_whilo got=%0h want=0", wb_whilo); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL inv_valid got=%0h want=0", wb_valid); end
    total++; if (wb_wdata !== 32'h0000_0055) begin bad++; $display("FAIL inv_wdata got=%0h want=55", wb_wdata); end
    total++; if (wb_lo !== 32'h0000_0077) begin bad++; $display("FAIL inv_lo got=%0h want=77", wb_lo); end
    total++; if (retired_cnt !== exp_cnt) begin bad++; $display("FAIL inv_cnt got=%0d want=%0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_r0();
    set_mem(1'b1, 5'd0, 1'b1, 32'h0000_0077, 1'b0, '0, '0);
    step(); exp_cnt++;
    total++; if (wb_wd !== 5'd0 || wb_wreg !== 1'b1) begin bad++; $display("FAIL r0_pass got=%0d/%0h want=0/1", wb_wd, wb_wreg); end
    total++; if (retired_cnt !== exp_cnt) begin bad++; $display("FAIL r0_cnt got=%0d want=%0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_stall_bubble();
    set_mem(1'b1, 5'd7, 1'b1, 32'h0000_00BB, 1'b1, 32'h3, 32'h4);
    stall = 6'b010000;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (wb_wreg !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL bub_ctl[%0d] got=%0h/%0h want=0/0", i, wb_wreg, wb_valid); end
      total++; if (wb_wdata !== '0 || wb_whilo !== 1'b0) begin bad++; $display("FAIL bub_data[%0d] got=%0h/%0h want=0/0", i, wb_wdata, wb_whilo); end
      total++; if (retired_cnt !== exp_cnt) begin bad++; $display("FAIL bub_cnt[%0d] got=%0d want=%0d", i, retired_cnt, exp_cnt); end
    end
    stall = '0;
  endtask

  task automatic test_hold();
    set_mem(1'b1, 5'd12, 1'b1, 32'h1234_5678, 1'b0, '0, '0);
    step(); exp_cnt++;
    stall = 6'b110000;
    set_mem(1'b1, 5'd13, 1'b1, 32'h9999_9999, 1'b1, 32'h5, 32'h6);
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (wb_wdata !== 32'h1234_5678) begin bad++; $display("FAIL hold_wdata[%0d] got=%0h want=12345678", i, wb_wdata); end
      total++; if (wb_wd !== 5'd12 || wb_valid !== 1'b1 || wb_whilo !== 1'b0) begin bad++; $display("FAIL hold_ctl[%0d] got=%0d/%0h/%0h want=12/1/0", i, wb_wd, wb_valid, wb_whilo); end
      total++; if (retired_cnt !== exp_cnt) begin bad++; $display("FAIL hold_cnt[%0d] got=%0d want=%0d", i, retired_cnt, exp_cnt); end
    end
    stall = '0;
    set_mem(1'b1, 5'd14, 1'b1, 32'hCAFE_F00D, 1'b0, '0, '0);
    step(); exp_cnt++;
    total++; if (wb_wdata !== 32'hCAFE_F00D || wb_wd !== 5'd14) begin bad++; $display("FAIL release got=%0h/%0d want=cafef00d/14", wb_wdata, wb_wd); end
    total++; if (retired_cnt !== exp_cnt) begin bad++; $display("FAIL release_cnt got=%0d want=%0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    set_mem(1'b1, 5'd2, 1'b0, 32'h0, 1'b1, 32'h0000_1111, 32'h0000_2222);
    step(); exp_cnt++;
    total++; if (wb_whilo !== 1'b1 || wb_hi !== 32'h0000_1111) begin bad++; $display("FAIL pre_flush got=%0h/%0h want=1/1111", wb_whilo, wb_hi); end
    stall = 6'b110000; flush = 1'b1;
    set_mem(1'b1, 5'd2, 1'b0, 32'h0, 1'b1, 32'hDEAD_0000, 32'h0);
    step();
    total++; if (wb_whilo !== 1'b0 || wb_hi !== '0) begin bad++; $display("FAIL flush_hilo got=%0h/%0h want=0/0", wb_whilo, wb_hi); end
    total++; if (wb_valid !== 1'b0 || wb_lo !== '0) begin bad++; $display("FAIL flush_valid got=%0h/%0h want=0/0", wb_valid, wb_lo); end
    total++; if (retired_cnt !== exp_cnt) begin bad++; $display("FAIL flush_cnt got=%0d want=%0d", retired_cnt, exp_cnt); end
    stall = '0; flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] want;
    for (int i = 0; i < 6; i++) begin
      want = 32'h0100_0000 + DATA_W'(i * 3);
      set_mem(1'b1, ADDR_W'(i + 1), 1'b1, want, 1'b0, '0, '0);
      exp_q.push_back(want);
      step(); exp_cnt++;
      want = exp_q.pop_front();
      total++; if (wb_wdata !== want || wb_wd !== ADDR_W'(i + 1)) begin bad++; $display("FAIL b2b[%0d] got=%0h want=%0h", i, wb_wdata, want); end
    end
    total++; if (retired_cnt !== exp_cnt) begin bad++; $display("FAIL b2b_cnt got=%0d want=%0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_wrap();
    set_mem(1'b1, 5'd1, 1'b1, 32'h0000_00AA, 1'b0, '0, '0);
    while (exp_cnt != '1) begin
      step(); exp_cnt++;
    end
    total++; if (retired_cnt !== 4'hF) begin bad++; $display("FAIL wrap_full got=%0d want=15", retired_cnt); end
    step(); exp_cnt++;
    total++; if (retired_cnt !== 4'h0) begin bad++; $display("FAIL wrap_zero got=%0d want=0", retired_cnt); end
  endtask

  task automatic test_async_reset();
    set_mem(1'b1, 5'd8, 1'b1, 32'h0000_0042, 1'b0, '0, '0);
    step(); exp_cnt++;
    total++; if (wb_wreg !== 1'b1) begin bad++; $display("FAIL areset_pre got=%0h want=1", wb_wreg); end
    stall = 6'b110000;
    #2 rst = 1'b1;
    #1;
    total++; if (wb_wreg !== 1'b0 || wb_wdata !== '0) begin bad++; $display("FAIL areset_out got=%0h/%0h want=0/0", wb_wreg, wb_wdata); end
    total++; if (retired_cnt !== '0) begin bad++; $display("FAIL areset_cnt got=%0d want=0", retired_cnt); end
    #1 rst = 1'b0;
    stall = '0; exp_cnt = '0;
    step(); exp_cnt++;
    total++; if (retired_cnt !== exp_cnt || wb_wdata !== 32'h0000_0042) begin bad++; $display("FAIL restart got=%0d/%0h want=%0d/42", retired_cnt, wb_wdata, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_invalid_capture();
    test_r0();
    test_stall_bubble();
    test_hold();
    test_flush();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
